unary_psum_collector: RTL and testbench
=======================================

# unary_psum_collector

Output-side counterpart of the unary-temporal border multiplier: consumes the product bitstream (`i_bit`) and its stream-active qualifier (`i_bit_d`) for one MAC window and converts them back to binary. It counts product ones, applies the window's sign, adds the result to an incoming signed partial sum with saturation, and hands the result downstream on a valid/ready handshake. It sits at the column end of the 8-bit unary-temporal systolic array.

## Interface
- `WIDTH`, 8, operand width incl. sign; stream length ≤ 2^(WIDTH-1)-1
- `ACCW`, 16, signed partial-sum width
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `init` in 1: start of MAC window (same cycle the multiplier samples `init`)
- `clr` in 1: abort current window, return to IDLE
- `i_sign` in 1: XOR of operand signs, sampled when `init` is accepted
- `i_psum` in ACCW: signed partial sum to accumulate into, sampled when `init` is accepted
- `i_bit_d` in 1: stream-active qualifier from multiplier
- `i_bit` in 1: product bit; ignored when `i_bit_d`=0
- `o_psum` out ACCW: signed result; stable while `o_valid`=1
- `o_valid` out 1: result available
- `i_ready` in 1: downstream accepts when `o_valid & i_ready`
- `o_busy` out 1: state ≠ IDLE
- `o_sat` out 1: result clamped; valid with `o_valid`
- `o_err` out 1: stream overran max length; valid with `o_valid`

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `init`=1 → latch `i_sign`, `i_psum`; `ones`←0, `len`←0; → RUN.
- RUN, per cycle: if `i_bit_d`=1 → `len`+=1, `ones`+=`i_bit`. If `i_bit_d`=0 → window ends → compute result, → DONE.
- Overrun: `ones` and `len` are WIDTH-1 bits and never wrap. When `len`=2^(WIDTH-1)-1, the next RUN cycle is an end cycle regardless of `i_bit_d`. If `i_bit_d`=1 in that cycle, `o_err`←1 and that cycle's `i_bit` is dropped.
- Result: `sum = psum ± ones` (minus when `sign`=1). Compute at ACCW+1 bits, then clamp to [-2^(ACCW-1), 2^(ACCW-1)-1]. `o_sat`←1 iff clamped.
- DONE: `o_valid`=1; `o_psum`, `o_sat`, `o_err` held.
  - `i_ready`=1 → handshake completes.
  - If `init`=1 in the same cycle, start a new window directly (DONE→RUN, latch new sign/psum). Otherwise → IDLE.
  - `init` while `o_valid`=1 and `i_ready`=0 is ignored.
- `init` in RUN is ignored.
- `clr` (any state, priority over `init` and handshake) → IDLE next cycle, `o_valid`←0, counters←0. `o_psum` retains its last value.
- `rst` (priority over all): state IDLE; `o_psum`=0; `o_valid`=0; `o_sat`=0; `o_err`=0; `o_busy`=0; internal regs 0. Reset mid-RUN discards the window.

## Timing
- Cycle 0: `init` high at the edge. Cycles 1..N: multiplier drives `i_bit_d`=1 for N = operand magnitude.
- Cycle N+1: `i_bit_d`=0 is sampled. `o_valid`=1 from cycle N+2, so latency from `init` is N+2 cycles.
- N=0: `o_valid` at cycle 2, `o_psum` = `i_psum`.
- `o_busy`=1 from cycle 1 until the cycle after handshake or `clr`.
- Back-to-back: handshake plus `init` in cycle k → RUN from k+1, no IDLE gap. `o_valid` drops in k+1.
- All outputs registered. No combinational path from `i_ready` or `i_bit` to any output.

## Test plan
- `i_psum`=100, `sign`=0, N=5, `i_bit`=1 throughout. Required: `o_valid` at cycle 7, `o_psum`=105, `o_sat`=0.
- `i_psum`=10, `sign`=1, N=40, `i_bit`=1 on 20 of those cycles, `i_bit`=1 also while `i_bit_d`=0. Required: `o_psum`=-10; ones outside the window are not counted.
- `i_psum`=32760, `sign`=0, 20 ones. Required: `o_psum`=32767, `o_sat`=1. Mirror case: `i_psum`=-32760, `sign`=1 → -32768, `o_sat`=1.
- Backpressure: hold `i_ready`=0 for 3 cycles after `o_valid`, and pulse `init` during the stall.
  - Required: `o_psum` stable; `init` ignored.
  - Then `i_ready`=1 with `init`=1 → `o_valid` drops next cycle and the new window's result appears N+1 cycles later.
- `clr` at cycle 3 of an N=10 window. Required: IDLE, `o_valid` never asserts, `o_busy`=0 next cycle. `rst` mid-RUN gives the same outcome plus `o_psum`=0.
- Overrun: `i_bit_d`=1 for 130 cycles, `i_bit`=1 throughout, `i_psum`=0. Required: `o_psum`=127, `o_err`=1, `o_valid` at cycle 129.

Source files
------------

// File: rtl/unary_psum_collector_if.sv
// Bus bundle between the unary product stream / partial-sum source and the collector.
// The slave side is the collector; the master side drives window control and the stream.
interface unary_psum_collector_if #(
  parameter int ACCW = 16
);
  logic            init;
  logic            clr;
  logic            i_sign;
  logic [ACCW-1:0] i_psum;
  logic            i_bit_d;
  logic            i_bit;
  logic            i_ready;
  logic [ACCW-1:0] o_psum;
  logic            o_valid;
  logic            o_busy;
  logic            o_sat;
  logic            o_err;

  modport master (
    output init, clr, i_sign, i_psum, i_bit_d, i_bit, i_ready,
    input  o_psum, o_valid, o_busy, o_sat, o_err
  );

  modport slave (
    input  init, clr, i_sign, i_psum, i_bit_d, i_bit, i_ready,
    output o_psum, o_valid, o_busy, o_sat, o_err
  );
endinterface

// File: rtl/unary_psum_collector.sv
// Converts one window of unary product bits back to binary, applies the window sign and
// accumulates into a signed partial sum with saturation; result leaves on valid/ready.
module unary_psum_collector #(
  parameter int WIDTH = 8,
  parameter int ACCW  = 16
) (
  input logic                    clk,
  input logic                    rst,
  unary_psum_collector_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = WIDTH - 1;
  localparam logic [CW-1:0]   LEN_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [ACCW-1:0] PSUM_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] PSUM_MIN = {1'b1, {(ACCW-1){1'b0}}};

  state_t          r_state, w_state;
  logic            r_sign, w_sign;
  logic [ACCW-1:0] r_psum, w_psum;
  logic [CW-1:0]   r_ones, w_ones;
  logic [CW-1:0]   r_len, w_len;
  logic [ACCW-1:0] r_out, w_out;
  logic            r_sat, w_sat;
  logic            r_err, w_err;

  logic            w_end;
  logic            w_start;
  logic [ACCW:0]   w_psum_ext;
  logic [ACCW:0]   w_ones_ext;
  logic [ACCW:0]   w_sum;
  logic            w_ovf;
  logic [ACCW-1:0] w_clamped;

  // A full-length stream forces the window closed so the counters never wrap.
  assign w_end   = !bus.i_bit_d || (r_len == LEN_MAX);
  assign w_start = bus.init && ((r_state == IDLE) || ((r_state == DONE) && bus.i_ready));

  // One guard bit above ACCW; overflow shows up as the top two bits disagreeing.
  assign w_psum_ext = {r_psum[ACCW-1], r_psum};
  assign w_ones_ext = {{(ACCW+1-CW){1'b0}}, r_ones};
  assign w_sum      = r_sign ? (w_psum_ext - w_ones_ext) : (w_psum_ext + w_ones_ext);
  assign w_ovf      = w_sum[ACCW] ^ w_sum[ACCW-1];
  assign w_clamped  = !w_ovf ? w_sum[ACCW-1:0] : (w_sum[ACCW] ? PSUM_MIN : PSUM_MAX);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    w_state = r_state;
    w_sign  = r_sign;
    w_psum  = r_psum;
    w_ones  = r_ones;
    w_len   = r_len;
    w_out   = r_out;
    w_sat   = r_sat;
    w_err   = r_err;

    case (r_state)
      IDLE: ;
      RUN: begin
        if (w_end) begin
          w_state = DONE;
          w_out   = w_clamped;
          w_sat   = w_ovf;
          w_err   = bus.i_bit_d;
        end else begin
          w_len  = r_len + CNT_ONE;
          w_ones = r_ones + {{(CW-1){1'b0}}, bus.i_bit};
        end
      end
      DONE: begin
        if (bus.i_ready) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase

    if (w_start) begin
      w_state = RUN;
      w_sign  = bus.i_sign;
      w_psum  = bus.i_psum;
      w_ones  = '0;
      w_len   = '0;
    end

    if (bus.clr) begin
      w_state = IDLE;
      w_ones  = '0;
      w_len   = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    if (rst) begin
      r_state <= IDLE;
      r_sign  <= 1'b0;
      r_psum  <= '0;
      r_ones  <= '0;
      r_len   <= '0;
      r_out   <= '0;
      r_sat   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sign  <= w_sign;
      r_psum  <= w_psum;
      r_ones  <= w_ones;
      r_len   <= w_len;
      r_out   <= w_out;
      r_sat   <= w_sat;
      r_err   <= w_err;
    end
  end

  assign bus.o_psum  = r_out;
  assign bus.o_valid = (r_state == DONE);
  assign bus.o_busy  = (r_state != IDLE);
  assign bus.o_sat   = r_sat;
  assign bus.o_err   = r_err;

endmodule

// File: tb/tb_unary_psum_collector.sv
// Randomized self-checking bench for unary_psum_collector against a behavioural
// model of the window (count ones, apply sign, saturate) and its cycle latency.
module tb_unary_psum_collector;
  localparam int WIDTH   = 8;
  localparam int ACCW    = 16;
  localparam int LEN_MAX = (1 << (WIDTH - 1)) - 1;
  localparam int SUM_MAX = (1 << (ACCW - 1)) - 1;
  localparam int SUM_MIN = -(1 << (ACCW - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad = 0;
  int cur_cycle = 0;
  int valid_cycle = -1;
  int last_exp = 0;

  always #5 clk = ~clk;

  unary_psum_collector_if #(.ACCW(ACCW)) bus ();

  unary_psum_collector #(.WIDTH(WIDTH), .ACCW(ACCW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cur_cycle++;
    if (bus.o_valid === 1'b1 && valid_cycle < 0) valid_cycle = cur_cycle;
  endtask

  task automatic model(input int psum, input bit sign, input int ones,
                       output int exp_psum, output bit exp_sat);
    int s;
    s = sign ? psum - ones : psum + ones;
    exp_sat = 1'b0;
    if (s > SUM_MAX) begin
      s = SUM_MAX;
      exp_sat = 1'b1;
    end else if (s < SUM_MIN) begin
      s = SUM_MIN;
      exp_sat = 1'b1;
    end
    exp_psum = s;
  endtask

  task automatic start_window(input int psum, input bit sign);
    bus.init    = 1'b1;
    bus.i_sign  = sign;
    bus.i_psum  = ACCW'(psum);
    bus.i_bit_d = 1'b0;
    bus.i_bit   = 1'($urandom_range(1));
    cur_cycle   = 0;
    valid_cycle = -1;
    step();
    bus.init   = 1'b0;
    bus.i_sign = ~sign;
    bus.i_psum = ACCW'($urandom);
  endtask

  task automatic stream(input int n, input int density, input bit alt,
                        input bit init_noise, output int ones);
    ones = 0;
    for (int c = 1; c <= n; c++) begin
      bus.i_bit_d = 1'b1;
      bus.i_bit   = alt ? (c % 2 == 0) : ($urandom_range(99) < density);
      bus.init    = init_noise ? ($urandom_range(3) == 0) : 1'b0;
      if (init_noise) bus.i_psum = ACCW'($urandom);
      if (c <= LEN_MAX && bus.i_bit) ones++;
      step();
    end
    bus.init    = 1'b0;
    bus.i_bit_d = 1'b0;
    bus.i_bit   = 1'($urandom_range(1));
  endtask

  task automatic wait_valid();
    int budget = 0;
    bus.i_bit_d = 1'b0;
    while (valid_cycle < 0 && budget < 300) begin
      bus.i_bit = 1'($urandom_range(1));
      step();
      budget++;
    end
  endtask

  task automatic check_result(input string name, input int exp_psum, input bit exp_sat,
                              input bit exp_err, input int exp_lat);
    total++;
    if (valid_cycle !== exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, valid_cycle, exp_lat);
    end
    total++;
    if (bus.o_psum !== ACCW'(exp_psum)) begin
      bad++;
      $display("FAIL %s o_psum: got %0d want %0d", name, $signed(bus.o_psum), exp_psum);
    end
    total++;
    if (bus.o_sat !== exp_sat) begin
      bad++;
      $display("FAIL %s o_sat: got %b want %b", name, bus.o_sat, exp_sat);
    end
    total++;
    if (bus.o_err !== exp_err) begin
      bad++;
      $display("FAIL %s o_err: got %b want %b", name, bus.o_err, exp_err);
    end
    last_exp = exp_psum;
  endtask

  task automatic finish_window(input string name, input int exp_psum, input bit exp_sat,
                               input bit exp_err, input int exp_lat);
    wait_valid();
    check_result(name, exp_psum, exp_sat, exp_err, exp_lat);
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s handshake: valid=%b busy=%b want 0 0", name, bus.o_valid, bus.o_busy);
    end
  endtask

  task automatic run_window(input string name, input int psum, input bit sign, input int n,
                            input int density, input bit alt, input bit init_noise);
    int ones, e;
    bit s;
    start_window(psum, sign);
    stream(n, density, alt, init_noise, ones);
    model(psum, sign, ones, e, s);
    finish_window(name, e, s, n > LEN_MAX, (n > LEN_MAX) ? LEN_MAX + 2 : n + 2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    total++;
    if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset o_valid: got %b want 0", bus.o_valid); end
    total++;
    if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL reset o_busy: got %b want 0", bus.o_busy); end
    total++;
    if (bus.o_psum !== '0) begin bad++; $display("FAIL reset o_psum: got %0d want 0", bus.o_psum); end
    total++;
    if (bus.o_sat !== 1'b0 || bus.o_err !== 1'b0) begin
      bad++;
      $display("FAIL reset flags: sat=%b err=%b want 0 0", bus.o_sat, bus.o_err);
    end
  endtask

  task automatic test_basic();
    run_window("basic", 100, 1'b0, 5, 100, 1'b0, 1'b0);
  endtask

  task automatic test_window_noise();
    run_window("noise", 10, 1'b1, 40, 0, 1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    run_window("sat_pos", 32760, 1'b0, 20, 100, 1'b0, 1'b0);
    run_window("sat_neg", -32760, 1'b1, 20, 100, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int psum, n;
      bit sign;
      sign = 1'($urandom_range(1));
      n    = (i == 0) ? 0 : $urandom_range(60);
      if (i % 3 == 1)      psum = SUM_MAX - $urandom_range(40);
      else if (i % 3 == 2) psum = SUM_MIN + $urandom_range(40);
      else                 psum = $urandom_range(65535) - 32768;
      run_window("random", psum, sign, n, $urandom_range(100), 1'b0, 1'b1);
    end
  endtask

  task automatic test_clr();
    start_window(777, 1'b0);
    for (int c = 1; c <= 2; c++) begin
      bus.i_bit_d = 1'b1; bus.i_bit = 1'b1; step();
    end
    bus.clr = 1'b1; bus.i_bit_d = 1'b1; bus.init = 1'b1;
    step();
    bus.clr = 1'b0; bus.init = 1'b0;
    total++;
    if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL clr state: busy=%b valid=%b want 0 0", bus.o_busy, bus.o_valid);
    end
    total++;
    if (bus.o_psum !== ACCW'(last_exp)) begin
      bad++;
      $display("FAIL clr o_psum retained: got %0d want %0d", $signed(bus.o_psum), last_exp);
    end
    for (int c = 4; c <= 15; c++) begin
      bus.i_bit_d = (c <= 10); bus.i_bit = 1'b1; step();
    end
    bus.i_bit_d = 1'b0;
    total++;
    if (valid_cycle !== -1) begin
      bad++;
      $display("FAIL clr no valid: got valid at cycle %0d want never", valid_cycle);
    end
  endtask

  task automatic test_backpressure();
    int ones, e, e2;
    bit s, s2;
    int n2;
    start_window(-500, 1'b0);
    stream(6, 50, 1'b0, 1'b0, ones);
    model(-500, 1'b0, ones, e, s);
    wait_valid();
    check_result("bp_first", e, s, 1'b0, 8);
    for (int k = 0; k < 3; k++) begin
      bus.i_ready = 1'b0;
      bus.init    = (k == 1);
      bus.i_psum  = ACCW'(1234);
      bus.i_sign  = 1'b1;
      step();
      bus.init = 1'b0;
      total++;
      if (bus.o_valid !== 1'b1 || bus.o_psum !== ACCW'(e)) begin
        bad++;
        $display("FAIL bp_stall: valid=%b psum=%0d want 1 %0d", bus.o_valid, $signed(bus.o_psum), e);
      end
    end
    n2 = $urandom_range(3, 12);
    bus.i_ready = 1'b1;
    bus.init    = 1'b1;
    bus.i_psum  = ACCW'(-42);
    bus.i_sign  = 1'b1;
    cur_cycle   = 0;
    valid_cycle = -1;
    step();
    bus.i_ready = 1'b0;
    bus.init    = 1'b0;
    bus.i_psum  = ACCW'($urandom);
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b1) begin
      bad++;
      $display("FAIL bp_b2b: valid=%b busy=%b want 0 1", bus.o_valid, bus.o_busy);
    end
    stream(n2, 70, 1'b0, 1'b0, ones);
    model(-42, 1'b1, ones, e2, s2);
    finish_window("bp_second", e2, s2, 1'b0, n2 + 2);
  endtask

  task automatic test_rst_mid_run();
    start_window(555, 1'b1);
    for (int c = 1; c <= 2; c++) begin
      bus.i_bit_d = 1'b1; bus.i_bit = 1'b1; step();
    end
    rst = 1'b1; bus.i_bit_d = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid state: busy=%b valid=%b want 0 0", bus.o_busy, bus.o_valid);
    end
    total++;
    if (bus.o_psum !== '0) begin
      bad++;
      $display("FAIL rst_mid o_psum: got %0d want 0", $signed(bus.o_psum));
    end
    for (int c = 4; c <= 15; c++) begin
      bus.i_bit_d = (c <= 10); bus.i_bit = 1'b1; step();
    end
    bus.i_bit_d = 1'b0;
    total++;
    if (valid_cycle !== -1) begin
      bad++;
      $display("FAIL rst_mid no valid: got valid at cycle %0d want never", valid_cycle);
    end
  endtask

  task automatic test_overrun();
    run_window("overrun", 0, 1'b0, 130, 100, 1'b0, 1'b0);
    run_window("after_overrun", 3, 1'b1, 2, 100, 1'b0, 1'b0);
  endtask

  initial begin
    bus.init    = 1'b0;
    bus.clr     = 1'b0;
    bus.i_sign  = 1'b0;
    bus.i_psum  = '0;
    bus.i_bit_d = 1'b0;
    bus.i_bit   = 1'b0;
    bus.i_ready = 1'b0;
    test_reset();
    test_basic();
    test_window_noise();
    test_saturation();
    test_clr();
    test_random();
    test_backpressure();
    test_rst_mid_run();
    test_overrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
